// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/logic, iterative shift-add MUL and
// restoring DIV sharing one hi/lo/operand datapath.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Opcode,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVF,
  output logic             DIV0,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010,
                         OP_DIV = 3'b011, OP_OR  = 3'b100, OP_NOR = 3'b101,
                         OP_NAND = 3'b110, OP_AND = 3'b111;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d, rem_q, rem_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             div0_q, div0_d, done_q, done_d;

  // MUL: hi:lo is the product, lo starts as the multiplier and shifts out.
  // DIV: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_hi   = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        op_d  = Opcode;
        cnt_d = '0;
        if (Opcode == OP_MUL || (Opcode == OP_DIV && B != '0)) begin
          state_d = ITER;
          hi_d    = '0;
          lo_d    = (Opcode == OP_MUL) ? B : A;
          opnd_d  = (Opcode == OP_MUL) ? A : B;
        end else begin
          done_d  = 1'b1;
          rem_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          unique case (Opcode)
            OP_ADD:  {carry_d, res_d} = {1'b0, A} + {1'b0, B};
            OP_SUB:  begin res_d = A - B; carry_d = (A < B); end
            OP_DIV:  begin res_d = '1; rem_d = A; div0_d = 1'b1; end
            OP_OR:   res_d = A | B;
            OP_NOR:  res_d = ~(A | B);
            OP_NAND: res_d = ~(A & B);
            OP_AND:  res_d = A & B;
            default: res_d = res_q;
          endcase
        end
      end
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        hi_d  = (op_q == OP_MUL) ? mul_hi : div_hi;
        lo_d  = (op_q == OP_MUL) ? mul_lo : div_lo;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          carry_d = 1'b0;
          div0_d  = 1'b0;
          if (op_q == OP_MUL) begin
            res_d = mul_lo;
            rem_d = '0;
            ovf_d = |mul_hi;
          end else begin
            res_d = div_lo;
            rem_d = div_hi;
            ovf_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (done_d) ? (res_d == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign Result    = res_q;
  assign Remainder = rem_q;
  assign ZERO      = zero_q;
  assign CARRY     = carry_q;
  assign OVF       = ovf_q;
  assign DIV0      = div0_q;
  assign busy      = (state_q == ITER);
  assign done      = done_q;
endmodule
